fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage for the MIPS core, directly upstream of decode.
//  Holds the PC and runs the ibus valid/addr_ok/data_ok handshake.
//  Presents {instr, pc} to decode through a valid/ready interface with a
//  one-entry skid buffer, and applies redirects (branch/jump targets).
//  Keeps one fetch in flight while decode is stalled.
// PARAMETERS
//  RESET_PC   32'hbfc0_0000   PC of the first fetch after reset
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  reset          in   1   synchronous, active-high reset
//  ireq_valid     out  1   ibus address-phase request
//  ireq_addr      out  32  ibus fetch address, always word-aligned
//  iresp_addr_ok  in   1   ibus accepted the address this cycle
//  iresp_data_ok  in   1   ibus returns data this cycle
//  iresp_data     in   32  instruction word, valid with data_ok
//  redirect       in   1   one-cycle pulse: refetch from redirect_pc
//  redirect_pc    in   32  target; bits [1:0] ignored, forced to 2'b00
//  instr_valid    out  1   instr/instr_pc hold an instruction for decode
//  instr_ready    in   1   decode accepts instruction this cycle
//  instr          out  32  instruction word to decode
//  instr_pc       out  32  PC of instr
// BEHAVIOUR
//  Reset (reset=1 at posedge):
//   - pc=RESET_PC, state=REQ, drop=0.
//   - Output and skid slots empty: instr_valid=0, instr=0, instr_pc=0.
//   - ireq_valid=0 while reset is high.
//  Bus rules:
//   - ireq_addr=pc.
//   - Once ireq_valid=1 it stays high, with ireq_addr stable, until addr_ok.
//   - data_ok may arrive in the same cycle as addr_ok, or any later cycle.
//   - At most one request is outstanding.
//  State REQ: ireq_valid=1 only if the skid slot is empty.
//   - On addr_ok without data_ok: go to WAIT.
//   - On addr_ok with data_ok: handle the response as in WAIT, same cycle.
//  State WAIT: ireq_valid=0; on data_ok the response is processed:
//   - drop=1: discard data, drop<=0, state=REQ.
//   - Output slot empty or handshaking (instr_ready=1):
//     instr<=data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, state=REQ.
//   - Output full and not handshaking: skid<=data/pc, pc<=pc+4, state=REQ.
//     REQ stays idle (ireq_valid=0) until the skid slot drains.
//  Drain: on an output handshake with the skid slot full, skid -> output
//   next cycle, with no bubble.
//  Redirect, taking effect at the same edge:
//   - Output and skid slots cleared; instr_valid<=0, even if instr_ready=1.
//   - pc<=redirect_pc & ~3.
//   - In WAIT, or in REQ with addr_ok this cycle: drop<=1 and the in-flight
//     response is discarded; if data_ok is also this cycle, that data is
//     discarded and drop stays 0.
//   - In REQ without addr_ok: pending pc latched in redir_pc and applied
//     after addr_ok; drop<=1 for that request; ireq_addr unchanged.
//   - A later redirect overwrites a still-pending one.
//   - The issuer asserts redirect only after the delay-slot instruction
//     was accepted by decode.
//  Arithmetic: pc+4 wraps modulo 2^32 (32'hffff_fffc -> 0).
//  Reset mid-operation:
//   - Outstanding response is ignored.
//   - The next request uses RESET_PC.
//   - Bus must be reset together with this stage.
//  Throughput: 1 instr/cycle when the bus returns data_ok with addr_ok.
// TESTING
//  1 reset, bus always ready (addr_ok=data_ok=1), instr_ready=1
//    -> ireq_addr bfc00000,04,08...; instr_valid from cycle 2; pc tracks.
//  2 instr_ready=0 for 5 cycles
//    -> output+skid hold bfc00000/04; ireq_valid=0; release -> in order,
//       no loss or duplicate.
//  3 redirect to 0x80001003 while in WAIT
//    -> late data_ok dropped; next ireq_addr=80001000; instr_valid=0
//       until new data.
//  4 redirect while ireq_valid=1 and addr_ok held 0 for 3 cycles
//    -> ireq_addr stays stable; its data dropped; then fetch from target.
//  5 pc=fffffffc, data_ok=1 -> next ireq_addr=00000000.
//  6 reset asserted in WAIT with data_ok on the same cycle
//    -> data ignored; instr_valid=0; first new request bfc00000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the ibus request/response
// handshake and hands {instr, pc} to decode through a one-entry skid buffer.
package fetch_stage_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_addr_ok,
  input  logic            iresp_data_ok,
  input  logic [XLEN-1:0] iresp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);
  typedef enum logic [0:0] {S_REQ, S_WAIT} state_t;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            redir_pend_q, redir_pend_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  fetch_entry_t    out_q, out_d;
  logic            out_valid_q, out_valid_d;
  fetch_entry_t    skid_q, skid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            ireq_valid_q, ireq_valid_d;

  logic            addr_fire;
  logic            resp_fire;
  logic            handshake;
  logic [XLEN-1:0] target;
  fetch_entry_t    resp_entry;

  assign addr_fire  = ireq_valid_q & iresp_addr_ok;
  assign resp_fire  = iresp_data_ok & ((state_q == S_WAIT) | addr_fire);
  assign handshake  = out_valid_q & instr_ready;
  assign target     = redirect_pc & ALIGN_MASK;
  assign resp_entry = '{instr: iresp_data, pc: pc_q};

  // Next-state: decode-side drain first, then bus response and redirects.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (handshake) begin
      if (skid_valid_q) out_d = skid_q;
      out_valid_d  = skid_valid_q;
      skid_valid_d = 1'b0;
    end

    if (addr_fire && !resp_fire) state_d = S_WAIT;
    if (resp_fire)               state_d = S_REQ;

    if (redirect) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      redir_pend_d = 1'b0;
      if ((state_q == S_WAIT) || addr_fire) begin
        // A response arriving this very cycle is simply discarded.
        pc_d   = target;
        drop_d = !resp_fire;
      end else if (ireq_valid_q) begin
        // Address phase still open: keep ireq_addr stable, apply after addr_ok.
        redir_pend_d = 1'b1;
        redir_pc_d   = target;
      end else begin
        pc_d = target;
      end
    end else if (addr_fire && redir_pend_q) begin
      pc_d         = redir_pc_q;
      redir_pend_d = 1'b0;
      drop_d       = !resp_fire;
    end else if (resp_fire) begin
      if (drop_q) begin
        drop_d = 1'b0;
      end else begin
        pc_d = pc_q + PC_STEP;
        if (!out_valid_q || instr_ready) begin
          out_d       = resp_entry;
          out_valid_d = 1'b1;
        end else begin
          skid_d       = resp_entry;
          skid_valid_d = 1'b1;
        end
      end
    end

    ireq_valid_d = (state_d == S_REQ) && !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ireq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ireq_valid_q <= ireq_valid_d;
    end
  end

  assign ireq_valid  = ireq_valid_q;
  assign ireq_addr   = pc_q;
  assign instr_valid = out_valid_q;
  assign instr       = out_q.instr;
  assign instr_pc    = out_q.pc;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a small ibus responder, an in-order delivery model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;

  // ibus responder state and knobs
  logic        bus_busy;
  logic [31:0] pend_addr;
  int          lat_cnt;
  int          data_lat;
  int          addr_stall;
  logic        rec_req, rec_addr_ok, rec_data_ok, rec_reset;
  logic [31:0] rec_addr;

  // delivery model: decode must see consecutive PCs, restarting at each redirect
  logic        model_on, after_reset, after_redirect;
  logic [31:0] exp_pc;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_cycle();
    if (model_on) begin
      if (after_reset) begin
        chk("reset_ireq_valid", 32'(ireq_valid), 32'd0);
        chk("reset_instr_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_instr_pc", instr_pc, 32'd0);
      end else begin
        if (after_redirect) chk("flush_instr_valid", 32'(instr_valid), 32'd0);
        if (rec_req && !rec_addr_ok) begin
          chk("req_held", 32'(ireq_valid), 32'd1);
          chk("req_addr_stable", ireq_addr, rec_addr);
        end
        if (bus_busy) chk("one_outstanding", 32'(ireq_valid), 32'd0);
      end
      if (instr_valid) begin
        chk("instr_pc_order", instr_pc, exp_pc);
        chk("instr_word", instr, mem_word(instr_pc));
      end
    end
    if (reset) begin
      model_on = 1'b1;
      exp_pc   = RESET_PC;
    end else if (model_on) begin
      if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
      if (redirect) exp_pc = redirect_pc & ~32'd3;
    end
    after_reset    = reset;
    after_redirect = redirect && !reset;
    rec_req        = ireq_valid;
    rec_addr_ok    = iresp_addr_ok;
    rec_data_ok    = iresp_data_ok;
    rec_addr       = ireq_addr;
    rec_reset      = reset;
  endtask

  task automatic bus_update();
    if (rec_reset) begin
      bus_busy = 1'b0;
    end else if (bus_busy) begin
      if (rec_data_ok) bus_busy = 1'b0;
      else if (lat_cnt > 0) lat_cnt--;
    end else if (rec_req && rec_addr_ok && !rec_data_ok) begin
      bus_busy  = 1'b1;
      pend_addr = rec_addr;
      lat_cnt   = (data_lat > 0) ? data_lat - 1 : 0;
    end else if (rec_req && !rec_addr_ok && addr_stall > 0) begin
      addr_stall--;
    end
  endtask

  task automatic bus_drive();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = 32'd0;
    if (bus_busy) begin
      if (lat_cnt == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem_word(pend_addr);
      end
    end else if (ireq_valid && addr_stall == 0) begin
      iresp_addr_ok = 1'b1;
      if (data_lat == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem_word(ireq_addr);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    bus_update();
    #1;
    redirect = 1'b0;
    bus_drive();
  endtask

  // Leaves the bench in the first cycle after reset is released.
  task automatic do_reset();
    data_lat   = 0;
    addr_stall = 0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_instr(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (instr_valid) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b1;
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = 32'd0;
    bus_busy = 1'b0; pend_addr = 32'd0; lat_cnt = 0; data_lat = 0; addr_stall = 0;
    rec_req = 1'b0; rec_addr_ok = 1'b0; rec_data_ok = 1'b0; rec_reset = 1'b0; rec_addr = 32'd0;
    model_on = 1'b0; after_reset = 1'b0; after_redirect = 1'b0; exp_pc = 32'd0;

    // 1: bus always ready, decode always ready
    do_reset();
    chk("t1_c0_ireq_valid", 32'(ireq_valid), 32'd0);
    tick();
    chk("t1_c1_ireq_valid", 32'(ireq_valid), 32'd1);
    chk("t1_c1_ireq_addr", ireq_addr, 32'hbfc0_0000);
    chk("t1_c1_instr_valid", 32'(instr_valid), 32'd0);
    for (int k = 2; k < 8; k++) begin
      tick();
      chk("t1_instr_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr_pc", instr_pc, 32'hbfc0_0000 + 32'(4 * (k - 2)));
      chk("t1_ireq_addr", ireq_addr, 32'hbfc0_0000 + 32'(4 * (k - 1)));
    end

    // 2: decode stalls, output and skid fill, fetch idles, then drains in order
    do_reset();
    tick();
    instr_ready = 1'b0;
    tick();
    chk("t2_c2_instr_pc", instr_pc, 32'hbfc0_0000);
    for (int c = 3; c < 7; c++) begin
      tick();
      chk("t2_hold_valid", 32'(instr_valid), 32'd1);
      chk("t2_hold_pc", instr_pc, 32'hbfc0_0000);
      chk("t2_idle_ireq", 32'(ireq_valid), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    chk("t2_drain_pc", instr_pc, 32'hbfc0_0004);
    chk("t2_drain_ireq", 32'(ireq_valid), 32'd1);
    chk("t2_drain_addr", ireq_addr, 32'hbfc0_0008);
    tick();
    chk("t2_next_pc", instr_pc, 32'hbfc0_0008);

    // 3: redirect while waiting for data
    do_reset();
    data_lat = 3;
    tick();
    tick();
    chk("t3_wait_ireq", 32'(ireq_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h8000_1003;
    tick();
    chk("t3_c3_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("t3_c4_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("t3_c5_ireq_valid", 32'(ireq_valid), 32'd1);
    chk("t3_c5_ireq_addr", ireq_addr, 32'h8000_1000);
    chk("t3_c5_instr_valid", 32'(instr_valid), 32'd0);
    data_lat = 1;
    wait_instr(10, seen);
    chk("t3_new_data_seen", 32'(seen), 32'd1);
    chk("t3_new_pc", instr_pc, 32'h8000_1000);

    // 4: redirect while the address phase is stalled
    do_reset();
    addr_stall = 3;
    tick();
    redirect = 1'b1; redirect_pc = 32'h8000_2000;
    for (int c = 2; c < 5; c++) begin
      tick();
      chk("t4_ireq_valid", 32'(ireq_valid), 32'd1);
      chk("t4_ireq_addr", ireq_addr, 32'hbfc0_0000);
    end
    tick();
    chk("t4_target_addr", ireq_addr, 32'h8000_2000);
    chk("t4_dropped", 32'(instr_valid), 32'd0);
    tick();
    chk("t4_target_pc", instr_pc, 32'h8000_2000);

    // 5: PC wraps; redirect coincides with addr_ok+data_ok
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'hffff_fffc;
    tick();
    chk("t5_addr_top", ireq_addr, 32'hffff_fffc);
    chk("t5_flushed", 32'(instr_valid), 32'd0);
    tick();
    chk("t5_pc_top", instr_pc, 32'hffff_fffc);
    chk("t5_addr_wrap", ireq_addr, 32'h0000_0000);
    tick();
    chk("t5_pc_wrap", instr_pc, 32'h0000_0000);

    // 7: mixed stalls, latencies and redirects against the delivery model
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      data_lat    = $urandom_range(0, 2);
      if (addr_stall == 0 && $urandom_range(0, 7) == 0) addr_stall = $urandom_range(1, 3);
      if ($urandom_range(0, 15) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
      end
      tick();
    end
    instr_ready = 1'b1; data_lat = 0; addr_stall = 0;
    wait_instr(20, seen);
    chk("t7_live", 32'(seen), 32'd1);

    // 6: reset lands on a data_ok in WAIT
    do_reset();
    data_lat = 2;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_ireq_valid", 32'(ireq_valid), 32'd0);
    reset = 1'b0; data_lat = 0;
    tick();
    chk("t6_first_req", ireq_addr, 32'hbfc0_0000);
    chk("t6_first_req_valid", 32'(ireq_valid), 32'd1);
    chk("t6_no_stale", 32'(instr_valid), 32'd0);
    tick();
    chk("t6_first_pc", instr_pc, 32'hbfc0_0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
